// File: rtl/classifier_pkg.sv
// Shared types and constants for the classifier feeder slice.
package classifier_pkg;

  localparam int MATRIX_SIZE = 16;
  localparam int DATA_WIDTH  = 8;
  localparam int CLASS_CNT   = 6;
  localparam int FRAME_BYTES = 256;

  // One signed Q4.4 matrix element.
  typedef logic signed [DATA_WIDTH-1:0] q44_t;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    RESULT
  } feeder_state_t;

endpackage

// File: rtl/feeder_matrix_buf.sv
// Register array holding the assembled feature matrix. One element is written
// per cycle at (wr_row, wr_col); the whole array is visible to the classifier.
module feeder_matrix_buf #(
  parameter int MATRIX_SIZE = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_W      = $clog2(MATRIX_SIZE)
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            wr_en,
  input  logic [ADDR_W-1:0]                               wr_row,
  input  logic [ADDR_W-1:0]                               wr_col,
  input  logic [DATA_WIDTH-1:0]                           wr_data,
  output logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] mat
);

  // Store the incoming byte unmodified into its row/column cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat <= '0;
    end else if (wr_en) begin
      mat[wr_row][wr_col] <= wr_data;
    end
  end

endmodule

// File: rtl/classifier_feeder.sv
// Initiator side of the classifier start/done interface: collects a row-major
// byte frame into the matrix buffer, kicks the classifier, waits for done with
// a timeout, and offers the class index on a valid/ready result port.
module classifier_feeder #(
  parameter int MATRIX_SIZE    = classifier_pkg::MATRIX_SIZE,
  parameter int DATA_WIDTH     = classifier_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [DATA_WIDTH-1:0]                           s_data,
  input  logic                                            s_valid,
  input  logic                                            s_last,
  output logic                                            s_ready,
  output logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] mat_out,
  output logic                                            start,
  input  logic                                            done,
  input  logic [3:0]                                      max_in,
  output logic [3:0]                                      res_class,
  output logic                                            res_valid,
  input  logic                                            res_ready,
  output logic                                            busy,
  output logic                                            frame_err
);

  import classifier_pkg::*;

  localparam int ADDR_W = $clog2(MATRIX_SIZE);
  localparam int CNT_W  = $clog2(MATRIX_SIZE * MATRIX_SIZE);
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(MATRIX_SIZE * MATRIX_SIZE - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES - 1);

  feeder_state_t     state;
  feeder_state_t     state_next;
  logic [CNT_W-1:0]  byte_cnt;
  logic [TCNT_W-1:0] tmo_cnt;
  logic              rst_seen;
  logic              accept;
  logic              wr_en;
  logic              byte_clr;
  logic              byte_inc;
  logic              tmo_clr;
  logic              tmo_inc;
  logic              capture;
  logic              res_clr;
  logic              start_next;
  logic              err_next;

  // s_ready is held low until the first clock after reset has been seen.
  assign s_ready = (state == LOAD) && rst_seen;
  assign accept  = s_valid && s_ready;

  feeder_matrix_buf #(
    .MATRIX_SIZE (MATRIX_SIZE),
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_W      (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_row  (byte_cnt[CNT_W-1:ADDR_W]),
    .wr_col  (byte_cnt[ADDR_W-1:0]),
    .wr_data (s_data),
    .mat     (mat_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the per-cycle control strobes for counters and outputs.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    byte_clr   = 1'b0;
    byte_inc   = 1'b0;
    tmo_clr    = 1'b0;
    tmo_inc    = 1'b0;
    capture    = 1'b0;
    res_clr    = 1'b0;
    start_next = 1'b0;
    err_next   = 1'b0;
    case (state)
      LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if ((byte_cnt == LAST_IDX) && s_last) begin
            state_next = START;
            start_next = 1'b1;
            byte_clr   = 1'b1;
          end else if (s_last || (byte_cnt == LAST_IDX)) begin
            err_next = 1'b1;
            byte_clr = 1'b1;
          end else begin
            byte_inc = 1'b1;
          end
        end
      end
      START: begin
        state_next = WAIT;
        tmo_clr    = 1'b1;
      end
      WAIT: begin
        if (done) begin
          state_next = RESULT;
          capture    = 1'b1;
        end else if (tmo_cnt == TCNT_MAX) begin
          state_next = LOAD;
          err_next   = 1'b1;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      RESULT: begin
        if (res_valid && res_ready) begin
          state_next = LOAD;
          res_clr    = 1'b1;
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // Byte position within the frame and cycles spent waiting for done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (byte_clr) begin
        byte_cnt <= '0;
      end else if (byte_inc) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (tmo_clr) begin
        tmo_cnt <= '0;
      end else if (tmo_inc) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // Registered handshake outputs and the captured class index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_seen  <= 1'b0;
      start     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_class <= '0;
    end else begin
      rst_seen  <= 1'b1;
      start     <= start_next;
      frame_err <= err_next;
      busy      <= (state_next != LOAD);
      if (capture) begin
        res_valid <= 1'b1;
        res_class <= max_in;
      end else if (res_clr) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_classifier_feeder.sv
// Self-checking bench for classifier_feeder: randomized frames and gaps are
// scored against a frame-level reference of the matrix and handshake timing.
module tb_classifier_feeder;

  localparam int MS    = 16;
  localparam int DW    = 8;
  localparam int TO    = 4096;
  localparam int FRAME = MS * MS;

  logic                            clk = 1'b0;
  logic                            rst_n = 1'b0;
  logic [DW-1:0]                   s_data = '0;
  logic                            s_valid = 1'b0;
  logic                            s_last = 1'b0;
  logic                            s_ready;
  logic [MS-1:0][MS-1:0][DW-1:0]   mat_out;
  logic                            start;
  logic                            done = 1'b0;
  logic [3:0]                      max_in = '0;
  logic [3:0]                      res_class;
  logic                            res_valid;
  logic                            res_ready = 1'b0;
  logic                            busy;
  logic                            frame_err;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mat [FRAME];
  int exp_cnt = 0;

  classifier_feeder #(
    .MATRIX_SIZE    (MS),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .mat_out   (mat_out),
    .start     (start),
    .done      (done),
    .max_in    (max_in),
    .res_class (res_class),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkMatrix(input string tag);
    int bad;
    bad = 0;
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++)
        if (mat_out[r][c] !== ref_mat[r*MS + c]) bad++;
    checkOutput(tag, bad, 0);
  endtask

  // Offer one byte (after random idle gaps), wait for acceptance, score the result.
  task automatic applyStimulus(input logic [DW-1:0] d, input bit last, input int gapPct);
    int guard;
    while ($urandom_range(0, 99) < gapPct) begin
      s_valid = 1'b0;
      s_data  = DW'($urandom);
      s_last  = 1'($urandom);
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    guard = 0;
    while (s_ready !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (s_ready !== 1'b1) begin
      checkOutput("s_ready_wait", 32'(s_ready), 1);
      s_valid = 1'b0;
      return;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    ref_mat[exp_cnt] = d;
    if (exp_cnt == FRAME - 1 && last) begin
      checkOutput("start_after_last", start, 1);
      checkOutput("err_on_good_frame", frame_err, 0);
      checkOutput("s_ready_in_start", s_ready, 0);
      checkOutput("busy_in_start", busy, 1);
      exp_cnt = 0;
    end else if (last || exp_cnt == FRAME - 1) begin
      checkOutput("frame_err_pulse", frame_err, 1);
      checkOutput("start_on_bad_frame", start, 0);
      exp_cnt = 0;
    end else begin
      checkOutput("start_mid_frame", start, 0);
      checkOutput("err_mid_frame", frame_err, 0);
      exp_cnt++;
    end
  endtask

  // pattern 0: byte k = k mod 128, otherwise random; s_last only at lastIdx.
  task automatic sendFrame(input int n, input int lastIdx, input int gapPct, input int pattern);
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = (pattern == 0) ? DW'(k % 128) : DW'($urandom);
      applyStimulus(d, k == lastIdx, gapPct);
    end
  endtask

  // Called on the negedge where start is seen: wait, return done, stall, handshake.
  task automatic runClassify(input int waitCycles, input logic [3:0] cls, input int stall);
    int readyHigh;
    int resEarly;
    readyHigh = 0;
    resEarly  = 0;
    @(negedge clk);
    checkOutput("start_one_cycle", start, 0);
    checkOutput("busy_wait", busy, 1);
    for (int i = 0; i < waitCycles; i++) begin
      s_valid = 1'($urandom);
      s_data  = DW'($urandom);
      s_last  = 1'($urandom);
      if (s_ready) readyHigh++;
      if (res_valid) resEarly++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    checkOutput("s_ready_low_wait", readyHigh, 0);
    checkOutput("res_before_done", resEarly, 0);
    done   = 1'b1;
    max_in = cls;
    @(negedge clk);
    done   = 1'b0;
    max_in = 4'($urandom);
    checkOutput("res_valid_set", res_valid, 1);
    checkOutput("res_class", res_class, cls);
    for (int i = 0; i < stall; i++) begin
      done    = 1'b1;
      max_in  = ~cls;
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      @(negedge clk);
      checkOutput("res_valid_hold", res_valid, 1);
      checkOutput("res_class_hold", res_class, cls);
      checkOutput("s_ready_result", s_ready, 0);
    end
    done      = 1'b0;
    s_valid   = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("res_valid_clear", res_valid, 0);
    checkOutput("s_ready_after_hs", s_ready, 1);
    checkOutput("busy_clear", busy, 0);
    checkMatrix("mat_frozen");
  endtask

  // Assert reset between clock edges, check reset values, release on a negedge.
  task automatic resetDut();
    int nz;
    #2;
    rst_n = 1'b0;
    #1;
    nz = 0;
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++)
        if (mat_out[r][c] !== '0) nz++;
    checkOutput("rst_mat_zero", nz, 0);
    checkOutput("rst_start", start, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_class", res_class, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    checkOutput("rst_s_ready", s_ready, 0);
    for (int i = 0; i < FRAME; i++) ref_mat[i] = '0;
    exp_cnt   = 0;
    done      = 1'b0;
    s_valid   = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("s_ready_before_edge", s_ready, 0);
    @(negedge clk);
    checkOutput("s_ready_after_rst", s_ready, 1);
  endtask

  initial begin
    int cycles;
    int sawRes;
    for (int i = 0; i < FRAME; i++) ref_mat[i] = '0;

    // Reset held across clock edges.
    repeat (2) @(negedge clk);
    resetDut();

    // Back-to-back frame with known pattern, done after 40 cycles, 5-cycle stall.
    $display("[TB] full frame, no gaps");
    sendFrame(FRAME, FRAME - 1, 0, 0);
    checkOutput("mat_3_5", mat_out[3][5], 53);
    checkMatrix("mat_pattern");
    runClassify(39, 4'd4, 5);

    // Random data with 50% valid gaps.
    $display("[TB] random frame with gaps");
    sendFrame(FRAME, FRAME - 1, 50, 1);
    checkMatrix("mat_random_gaps");
    runClassify(1 + $urandom_range(0, 60), 4'($urandom), $urandom_range(0, 6));

    // Short frame, then a good frame.
    $display("[TB] short frame");
    sendFrame(101, 100, 20, 1);
    checkOutput("busy_after_short", busy, 0);
    checkMatrix("mat_after_short");
    sendFrame(FRAME, FRAME - 1, 20, 1);
    runClassify(10, 4'd9, 2);

    // Long frame (no s_last on the final byte), then a good frame.
    $display("[TB] long frame");
    sendFrame(FRAME, -1, 10, 1);
    sendFrame(FRAME, FRAME - 1, 10, 0);
    checkMatrix("mat_after_long");
    runClassify(3, 4'd15, 0);

    // Timeout: no done after start.
    $display("[TB] timeout");
    sendFrame(FRAME, FRAME - 1, 0, 1);
    cycles = 0;
    sawRes = 0;
    while (frame_err !== 1'b1 && cycles < TO + 20) begin
      @(negedge clk);
      cycles++;
      if (res_valid) sawRes++;
    end
    checkOutput("timeout_cycles", cycles, TO + 1);
    checkOutput("timeout_no_res", sawRes, 0);
    checkOutput("timeout_busy", busy, 0);
    checkOutput("timeout_s_ready", s_ready, 1);
    done   = 1'b1;
    max_in = 4'd7;
    @(negedge clk);
    done = 1'b0;
    checkOutput("done_in_load_ignored", res_valid, 0);
    checkOutput("busy_done_in_load", busy, 0);

    // Reset while waiting for done.
    $display("[TB] reset in WAIT");
    sendFrame(FRAME, FRAME - 1, 0, 1);
    repeat (5) @(negedge clk);
    resetDut();

    // Reset while a result is pending.
    $display("[TB] reset in RESULT");
    sendFrame(FRAME, FRAME - 1, 0, 1);
    @(negedge clk);
    done   = 1'b1;
    max_in = 4'd11;
    @(negedge clk);
    done = 1'b0;
    checkOutput("res_valid_pre_rst", res_valid, 1);
    resetDut();

    // A few fully random transactions after the resets.
    $display("[TB] random transactions");
    for (int t = 0; t < 3; t++) begin
      sendFrame(FRAME, FRAME - 1, $urandom_range(0, 60), 1);
      checkMatrix("mat_rand_txn");
      runClassify($urandom_range(0, 100), 4'($urandom), $urandom_range(0, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/classifier_feeder.md
Name: classifier_feeder

Overview:
- Initiator side of the classifier start/done interface.
- Accepts a 256-byte Q4.4 feature frame over a valid/ready byte stream and assembles it into the 16x16 matrix that the classifier reads.
- Pulses start, holds the matrix stable until done, captures the 4-bit class index and presents it on a valid/ready result port.
- Sits between the upstream feature-map producer and the classifier core.

Parameters:
- MATRIX_SIZE, 16, matrix rows and columns; frame length is MATRIX_SIZE*MATRIX_SIZE bytes.
- DATA_WIDTH, 8, element width, signed Q4.4.
- TIMEOUT_CYCLES, 4096, maximum number of cycles in WAIT before aborting.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  DATA_WIDTH  stream byte, signed Q4.4, row-major order (row0 col0 first).
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final byte of a frame.
- s_ready  out  1  feeder can accept a byte.
- mat_out  out  DATA_WIDTH x [MATRIX_SIZE][MATRIX_SIZE]  assembled matrix, driven to the classifier.
- start  out  1  one-cycle pulse to the classifier.
- done  in  1  classifier completion pulse.
- max_in  in  4  classifier class index, valid while done=1.
- res_class  out  4  captured class index.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- busy  out  1  high in START, WAIT and RESULT.
- frame_err  out  1  one-cycle pulse on a framing error or timeout.

Behaviour:
- Reset (async, rst_n=0): state=LOAD, byte counter=0, timeout counter=0, mat_out all 0, start=0, s_ready=0 during reset, res_class=0, res_valid=0, busy=0, frame_err=0.
- States: LOAD, START, WAIT, RESULT. All outputs are registered except s_ready, which is a decode of state==LOAD.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready: write mat_out[cnt/16][cnt%16] <= s_data, then cnt++.
  - Accepted byte at cnt==255 with s_last=1: go to START, cnt<=0.
  - Accepted byte with s_last=1 and cnt!=255 (short frame): frame_err pulse, cnt<=0, stay in LOAD. Already-written cells are not cleared.
  - Accepted byte at cnt==255 with s_last=0 (long frame): frame_err pulse, cnt<=0, stay in LOAD. Subsequent bytes start a new frame.
- START:
  - start=1 for exactly one cycle; s_ready=0; go to WAIT.
  - timeout counter <= 0.
- WAIT:
  - mat_out is frozen; no write occurs from START entry until RESULT exit.
  - On done=1: res_class<=max_in, res_valid<=1, go to RESULT.
  - Otherwise timeout counter++. When it reaches TIMEOUT_CYCLES-1 without done: frame_err pulse, go to LOAD, res_valid stays 0.
  - A done arriving in LOAD or RESULT is ignored.
- RESULT:
  - res_valid held at 1 and res_class stable until res_ready=1.
  - On res_valid&&res_ready: res_valid<=0, go to LOAD.
  - Zero-bubble: s_ready rises on the cycle after the handshake.
- Latency:
  - Last accepted byte to start=1 is 1 cycle.
  - done to res_valid=1 is 1 cycle.
  - Frame-to-frame overhead excluding the classifier is 3 cycles plus downstream stall.
- Counter widths: byte counter is $clog2(MATRIX_SIZE*MATRIX_SIZE) bits and never wraps inside a valid frame. Timeout counter is $clog2(TIMEOUT_CYCLES) bits and saturates.
- s_data is stored unmodified; no arithmetic is performed.
- rst_n deasserted mid-frame or mid-WAIT aborts immediately to reset values. The classifier is reset separately.
- s_valid ignored while s_ready=0; no data is lost because the upstream must hold the byte.

Decomposition:
- Shared package classifier_pkg:
  - state enum feeder_state_t {LOAD, START, WAIT, RESULT}.
  - constants MATRIX_SIZE, DATA_WIDTH, CLASS_CNT=6, FRAME_BYTES=256.
  - typedef for the Q4.4 element.
- One sub-module: feeder_matrix_buf, the 256-entry register array with write-enable and row/col address.
- The FSM and counters stay in the top.

Test Plan:
1. Reset values: hold rst_n=0 -> all outputs 0, s_ready=0. Release rst_n -> s_ready=1 next cycle.
2. Full frame, byte k = k mod 128, s_valid always 1, s_last on byte 255 -> mat_out[3][5]=53; start pulses once, 1 cycle after the last byte. Drive done=1 with max_in=4 after 40 cycles -> res_valid=1, res_class=4 next cycle. Hold res_ready=0 for 5 cycles -> values stable. Assert res_ready -> return to LOAD.
3. Random s_valid gaps (50%) over a full frame -> identical mat_out contents; s_ready=0 from START until RESULT exit, and no byte is accepted then.
4. s_last on byte 100 -> frame_err pulse, no start. Follow with a correct 256-byte frame -> normal start and result.
5. No done after start -> frame_err at TIMEOUT_CYCLES, state returns to LOAD, res_valid never asserts.
6. rst_n pulled low in WAIT and while res_valid=1 -> outputs return to reset values asynchronously. Next frame completes normally.
